decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 265 ++++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// RV32I decode stage followed by a DEPTH-entry queue of decoded instructions with an illegal-instruction counter.
// Optional macro DECODE_STRICT_EN: when defined, shift-immediates with non-canonical imm[31:25] decode as ILLEGAL.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5:0]                 out_op,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [31:0]                out_imm,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_raw,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           illegal_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
  typedef enum logic [5:0] {
    OP_ILLEGAL = 6'd0,  OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,
    OP_JALR    = 6'd4,  OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,
    OP_BGE     = 6'd8,  OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10, OP_LB    = 6'd11,
    OP_LH      = 6'd12, OP_LW    = 6'd13, OP_LBU   = 6'd14, OP_LHU   = 6'd15,
    OP_SB      = 6'd16, OP_SH    = 6'd17, OP_SW    = 6'd18, OP_ADDI  = 6'd19,
    OP_SLTI    = 6'd20, OP_SLTIU = 6'd21, OP_XORI  = 6'd22, OP_ORI   = 6'd23,
    OP_ANDI    = 6'd24, OP_SLLI  = 6'd25, OP_SRLI  = 6'd26, OP_SRAI  = 6'd27,
    OP_ADD     = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31,
    OP_SLTU    = 6'd32, OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35,
    OP_OR      = 6'd36, OP_AND   = 6'd37
  } op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH
  } imm_sel_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] raw;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  op_e        dec_op;
  imm_sel_e   imm_sel;
  logic       use_rd, use_rs1, use_rs2;
  logic       dec_illegal;
  entry_t     dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec_op  = OP_ILLEGAL;
    imm_sel = IMM_NONE;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (in_instr[1:0] == 2'b11) begin
      case (opcode)
        7'b0110111: begin dec_op = OP_LUI;   imm_sel = IMM_U; use_rd = 1'b1; end
        7'b0010111: begin dec_op = OP_AUIPC; imm_sel = IMM_U; use_rd = 1'b1; end
        7'b1101111: begin dec_op = OP_JAL;   imm_sel = IMM_J; use_rd = 1'b1; end
        7'b1100111: begin
          imm_sel = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
          if (funct3 == 3'b000) dec_op = OP_JALR;
        end
        7'b1100011: begin
          imm_sel = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
          case (funct3)
            3'b000:  dec_op = OP_BEQ;
            3'b001:  dec_op = OP_BNE;
            3'b100:  dec_op = OP_BLT;
            3'b101:  dec_op = OP_BGE;
            3'b110:  dec_op = OP_BLTU;
            3'b111:  dec_op = OP_BGEU;
            default: dec_op = OP_ILLEGAL;
          endcase
        end
        7'b0000011: begin
          imm_sel = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
          case (funct3)
            3'b000:  dec_op = OP_LB;
            3'b001:  dec_op = OP_LH;
            3'b010:  dec_op = OP_LW;
            3'b100:  dec_op = OP_LBU;
            3'b101:  dec_op = OP_LHU;
            default: dec_op = OP_ILLEGAL;
          endcase
        end
        7'b0100011: begin
          imm_sel = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
          case (funct3)
            3'b000:  dec_op = OP_SB;
            3'b001:  dec_op = OP_SH;
            3'b010:  dec_op = OP_SW;
            default: dec_op = OP_ILLEGAL;
          endcase
        end
        7'b0010011: begin
          imm_sel = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
          case (funct3)
            3'b000: dec_op = OP_ADDI;
            3'b010: dec_op = OP_SLTI;
            3'b011: dec_op = OP_SLTIU;
            3'b100: dec_op = OP_XORI;
            3'b110: dec_op = OP_ORI;
            3'b111: dec_op = OP_ANDI;
            3'b001: begin
              imm_sel = IMM_SH;
`ifdef DECODE_STRICT_EN
              dec_op = (funct7 == 7'h00) ? OP_SLLI : OP_ILLEGAL;
`else
              dec_op = OP_SLLI;
`endif
            end
            default: begin
              imm_sel = IMM_SH;
`ifdef DECODE_STRICT_EN
              if (funct7 == 7'h00)      dec_op = OP_SRLI;
              else if (funct7 == 7'h20) dec_op = OP_SRAI;
              else                      dec_op = OP_ILLEGAL;
`else
              dec_op = in_instr[30] ? OP_SRAI : OP_SRLI;
`endif
            end
          endcase
        end
        7'b0110011: begin
          use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
          if (funct7 == 7'h00) begin
            case (funct3)
              3'b000:  dec_op = OP_ADD;
              3'b001:  dec_op = OP_SLL;
              3'b010:  dec_op = OP_SLT;
              3'b011:  dec_op = OP_SLTU;
              3'b100:  dec_op = OP_XOR;
              3'b101:  dec_op = OP_SRL;
              3'b110:  dec_op = OP_OR;
              default: dec_op = OP_AND;
            endcase
          end else if (funct7 == 7'h20) begin
            case (funct3)
              3'b000:  dec_op = OP_SUB;
              3'b101:  dec_op = OP_SRA;
              default: dec_op = OP_ILLEGAL;
            endcase
          end
        end
        default: dec_op = OP_ILLEGAL;
      endcase
    end
  end

  assign dec_illegal = (dec_op == OP_ILLEGAL);

  // Illegal entries carry no register or immediate fields at all.
  always_comb begin
    dec.op  = dec_op;
    dec.rd  = (use_rd  && !dec_illegal) ? in_instr[11:7]  : 5'd0;
    dec.rs1 = (use_rs1 && !dec_illegal) ? in_instr[19:15] : 5'd0;
    dec.rs2 = (use_rs2 && !dec_illegal) ? in_instr[24:20] : 5'd0;
    dec.pc  = in_pc;
    dec.raw = in_instr;
    dec.imm = 32'd0;
    if (!dec_illegal) begin
      case (imm_sel)
        IMM_I:   dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
        IMM_S:   dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        IMM_B:   dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
        IMM_U:   dec.imm = {in_instr[31:12], 12'd0};
        IMM_J:   dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
        IMM_SH:  dec.imm = {27'd0, in_instr[24:20]};
        default: dec.imm = 32'd0;
      endcase
    end
  end

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push, pop;
  entry_t             head;

  assign in_ready  = (level_q < LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (push && dec_illegal && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head          = mem_q[rd_ptr_q];
  assign out_op        = head.op;
  assign out_rd        = head.rd;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_imm       = head.imm;
  assign out_pc        = head.pc;
  assign out_raw       = head.raw;
  assign out_illegal   = (head.op == OP_ILLEGAL);
  assign level         = level_q;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed testbench for decode_queue: decode fields, queue ordering/wrap, flush, counter saturation, async reset.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam logic [5:0] E_ILLEGAL = 6'd0, E_LUI = 6'd1, E_BEQ = 6'd5, E_ADDI = 6'd19, E_SLLI = 6'd25;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm, out_pc, out_raw;
  logic        out_illegal;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0] illegal_count;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [31:0] s_in_instr = 32'd0;
  logic        s_out_valid;
  logic [5:0]  s_out_op;
  logic [4:0]  s_out_rd, s_out_rs1, s_out_rs2;
  logic [31:0] s_out_imm, s_out_pc, s_out_raw;
  logic        s_out_illegal;
  logic [$clog2(DEPTH):0] s_level;
  logic [1:0]  s_illegal_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_pc(out_pc), .out_raw(out_raw),
    .out_illegal(out_illegal), .level(level), .illegal_count(illegal_count)
  );

  decode_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_instr(s_in_instr), .in_pc(32'd0),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_op(s_out_op),
    .out_rd(s_out_rd), .out_rs1(s_out_rs1), .out_rs2(s_out_rs2),
    .out_imm(s_out_imm), .out_pc(s_out_pc), .out_raw(s_out_raw),
    .out_illegal(s_out_illegal), .level(s_level), .illegal_count(s_illegal_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++; if (illegal_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", illegal_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0000_0100; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL addi_valid: got %b expected 1", out_valid); end
    tests_run++; if (out_op !== E_ADDI) begin tests_failed++; $display("FAIL addi_op: got %0d expected %0d", out_op, E_ADDI); end
    tests_run++; if (out_rd !== 5'd1) begin tests_failed++; $display("FAIL addi_rd: got %0d expected 1", out_rd); end
    tests_run++; if (out_rs1 !== 5'd0) begin tests_failed++; $display("FAIL addi_rs1: got %0d expected 0", out_rs1); end
    tests_run++; if (out_imm !== 32'd5) begin tests_failed++; $display("FAIL addi_imm: got %h expected 5", out_imm); end
    tests_run++; if (level !== 3'd1) begin tests_failed++; $display("FAIL addi_level: got %0d expected 1", level); end
    tests_run++; if (out_pc !== 32'h100) begin tests_failed++; $display("FAIL addi_pc: got %h expected 100", out_pc); end
    tests_run++; if (out_raw !== 32'h00500093) begin tests_failed++; $display("FAIL addi_raw: got %h expected 00500093", out_raw); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL addi_pop_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFE000EE3;
    step();
    tests_run++; if (out_op !== E_BEQ) begin tests_failed++; $display("FAIL b2b_beq_op: got %0d expected %0d", out_op, E_BEQ); end
    tests_run++; if (out_imm !== 32'hFFFFFFFC) begin tests_failed++; $display("FAIL b2b_beq_imm: got %h expected fffffffc", out_imm); end
    tests_run++; if (level !== 3'd1) begin tests_failed++; $display("FAIL b2b_level1: got %0d expected 1", level); end
    in_instr = 32'h800000B7;
    step();
    in_valid = 1'b0;
    tests_run++; if (out_op !== E_LUI) begin tests_failed++; $display("FAIL b2b_lui_op: got %0d expected %0d", out_op, E_LUI); end
    tests_run++; if (out_imm !== 32'h80000000) begin tests_failed++; $display("FAIL b2b_lui_imm: got %h expected 80000000", out_imm); end
    tests_run++; if (out_rd !== 5'd1) begin tests_failed++; $display("FAIL b2b_lui_rd: got %0d expected 1", out_rd); end
    tests_run++; if (level !== 3'd1) begin tests_failed++; $display("FAIL b2b_level2: got %0d expected 1", level); end
    step();
    out_ready = 1'b0;
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL b2b_drained: got %0d expected 0", level); end
  endtask

  task automatic test_full_wrap();
    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      tests_run++; if (level !== 3'(i > DEPTH ? DEPTH : i)) begin tests_failed++; $display("FAIL full_level_%0d: got %0d expected %0d", i, level, i); end
      if (i == DEPTH) begin
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
      end
      in_valid = 1'b1; in_instr = (32'(i + 1) << 20) | 32'h113;
      step();
    end
    in_valid = 1'b0;
    tests_run++; if (level !== 3'(DEPTH)) begin tests_failed++; $display("FAIL full_extra_rejected: got %0d expected %0d", level, DEPTH); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++; if (out_imm !== 32'(i + 1)) begin tests_failed++; $display("FAIL drain_order_%0d: got %0d expected %0d", i, out_imm, i + 1); end
      step();
    end
    out_ready = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
    step();
    in_instr = 32'h00000000;
    tests_run++; if (out_illegal !== 1'b1) begin tests_failed++; $display("FAIL ill_ffff_flag: got %b expected 1", out_illegal); end
    tests_run++; if (out_op !== E_ILLEGAL) begin tests_failed++; $display("FAIL ill_ffff_op: got %0d expected 0", out_op); end
    tests_run++; if (out_rd !== 5'd0 || out_rs1 !== 5'd0 || out_rs2 !== 5'd0) begin tests_failed++; $display("FAIL ill_regs: got %0d/%0d/%0d expected 0/0/0", out_rd, out_rs1, out_rs2); end
    tests_run++; if (out_imm !== 32'd0) begin tests_failed++; $display("FAIL ill_imm: got %h expected 0", out_imm); end
    step();
    in_instr = 32'h40001033;
    tests_run++; if (illegal_count !== 16'd2) begin tests_failed++; $display("FAIL ill_count: got %0d expected 2", illegal_count); end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    tests_run++; if (out_illegal !== 1'b1) begin tests_failed++; $display("FAIL ill_zero_flag: got %b expected 1", out_illegal); end
    step();
    tests_run++; if (out_op !== E_ILLEGAL) begin tests_failed++; $display("FAIL ill_rtype_f7_op: got %0d expected 0", out_op); end
    tests_run++; if (illegal_count !== 16'd3) begin tests_failed++; $display("FAIL ill_count3: got %0d expected 3", illegal_count); end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_instr = 32'h00500093;
      step();
    end
    tests_run++; if (level !== 3'(DEPTH)) begin tests_failed++; $display("FAIL flush_prefill: got %0d expected %0d", level, DEPTH); end
    flush = 1'b1; in_instr = 32'hFFFFFFFF; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL flush_level: got %0d expected 0", level); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    tests_run++; if (illegal_count !== 16'd3) begin tests_failed++; $display("FAIL flush_count_full: got %0d expected 3", illegal_count); end
    in_valid = 1'b1; in_instr = 32'h00500093;
    step();
    flush = 1'b1; in_instr = 32'hFFFFFFFF;
    step();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++; if (illegal_count !== 16'd3) begin tests_failed++; $display("FAIL flush_count_open: got %0d expected 3", illegal_count); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_slli();
    logic [5:0] exp_op;
`ifdef DECODE_STRICT_EN
    exp_op = E_ILLEGAL;
`else
    exp_op = E_SLLI;
`endif
    in_valid = 1'b1; in_instr = 32'h02009093;
    step();
    in_valid = 1'b0;
    tests_run++; if (out_op !== exp_op) begin tests_failed++; $display("FAIL slli_f7_op: got %0d expected %0d", out_op, exp_op); end
    out_ready = 1'b1;
    step();
    in_valid = 1'b1; in_instr = 32'h40105013;
    step();
    in_valid = 1'b0;
    tests_run++; if (out_imm !== 32'd1) begin tests_failed++; $display("FAIL srai_shamt: got %h expected 1", out_imm); end
    tests_run++; if (out_op !== 6'd27) begin tests_failed++; $display("FAIL srai_op: got %0d expected 27", out_op); end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_cnt_sat();
    s_in_valid = 1'b1; s_in_instr = 32'hFFFFFFFF;
    repeat (5) step();
    s_in_valid = 1'b0;
    tests_run++; if (s_illegal_count !== 2'd3) begin tests_failed++; $display("FAIL cnt_saturate: got %0d expected 3", s_illegal_count); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
    step();
    step();
    tests_run++; if (level !== 3'd2) begin tests_failed++; $display("FAIL areset_prefill: got %0d expected 2", level); end
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
    tests_run++; if (illegal_count !== 16'd0) begin tests_failed++; $display("FAIL areset_count: got %0d expected 0", illegal_count); end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests_run++; if (level !== 3'd1) begin tests_failed++; $display("FAIL areset_first_push: got %0d expected 1", level); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_full_wrap();
    test_illegal();
    test_flush();
    test_slli();
    test_cnt_sat();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
